// File: rtl/eth_pcs_block_sync.sv
// Rx PCS block-lock controller. It checks gearbox sync headers, requests
// single-bit gearbox slips until headers line up, and declares block lock.
// While locked, it monitors the invalid-header rate over fixed BER windows.
module eth_pcs_block_sync #(
  parameter int LOCK_CNT    = 64,
  parameter int INVALID_MAX = 16,
  parameter int SLIP_WAIT   = 4,
  parameter int BER_WIN     = 19531,
  parameter int BER_THRESH  = 16,
  parameter int W_SYNC      = 2
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_clk_en,
  input  logic              i_grbx_hdr_valid,
  input  logic [W_SYNC-1:0] i_grbx_hdr,
  output logic              o_grbx_slip,
  output logic              o_block_lock,
  output logic              o_hi_ber,
  output logic              o_link_up,
  output logic [7:0]        o_slip_cnt
);

  localparam int SH_W = $clog2(LOCK_CNT + 1);
  localparam int IV_W = $clog2(INVALID_MAX + 1);
  localparam int WT_W = $clog2(SLIP_WAIT + 1);
  localparam int BT_W = $clog2(BER_WIN + 1);
  localparam int BC_W = $clog2(BER_THRESH + 1);

  localparam logic [SH_W-1:0]   LOCK_V    = SH_W'(LOCK_CNT);
  localparam logic [IV_W-1:0]   INV_MAX_V = IV_W'(INVALID_MAX);
  localparam logic [WT_W-1:0]   WAIT_V    = WT_W'(SLIP_WAIT);
  localparam logic [BT_W-1:0]   BER_END_V = BT_W'(BER_WIN - 1);
  localparam logic [BC_W-1:0]   BER_TH_V  = BC_W'(BER_THRESH);
  localparam logic [W_SYNC-1:0] SYNC_DATA = W_SYNC'(2'b01);
  localparam logic [W_SYNC-1:0] SYNC_CTRL = W_SYNC'(2'b10);

  typedef enum logic [1:0] {ST_UNLOCK, ST_SLIP, ST_WAIT, ST_LOCK} state_t;

  state_t          state;
  logic [SH_W-1:0] sh_cnt;
  logic [IV_W-1:0] inv_cnt;
  logic [WT_W-1:0] wait_cnt;
  logic [BT_W-1:0] ber_tmr;
  logic [BC_W-1:0] ber_cnt;

  logic            hev;
  logic            hdr_ok;
  logic [SH_W-1:0] sh_inc;
  logic [IV_W-1:0] inv_nxt;
  logic [WT_W-1:0] wait_inc;
  logic [BC_W-1:0] ber_nxt;

  // Slip counter saturates so a long-lost link cannot wrap it back to zero.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // BER error count saturates at the threshold; beyond it no more detail is needed.
  function automatic logic [BC_W-1:0] ber_sat(input logic [BC_W-1:0] v, input logic inc);
    if (inc && (v != BER_TH_V)) return v + BC_W'(1);
    return v;
  endfunction

  assign hev      = i_clk_en & i_grbx_hdr_valid;
  assign hdr_ok   = (i_grbx_hdr == SYNC_DATA) || (i_grbx_hdr == SYNC_CTRL);
  assign sh_inc   = sh_cnt + SH_W'(1);
  assign inv_nxt  = hdr_ok ? inv_cnt : inv_cnt + IV_W'(1);
  assign wait_inc = wait_cnt + WT_W'(1);
  assign ber_nxt  = ber_sat(ber_cnt, hev & ~hdr_ok);

  // Both flags are registered, so link status carries no extra latency.
  assign o_link_up = o_block_lock & ~o_hi_ber;

  // Lock state machine: hunt for valid headers, slip, settle, and hold lock.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state        <= ST_UNLOCK;
      sh_cnt       <= '0;
      inv_cnt      <= '0;
      wait_cnt     <= '0;
      o_grbx_slip  <= 1'b0;
      o_block_lock <= 1'b0;
      o_slip_cnt   <= '0;
    end else if (i_clk_en) begin
      case (state)
        ST_UNLOCK: begin
          if (i_grbx_hdr_valid) begin
            if (!hdr_ok) begin
              state       <= ST_SLIP;
              sh_cnt      <= '0;
              inv_cnt     <= '0;
              o_grbx_slip <= 1'b1;
              o_slip_cnt  <= sat_inc8(o_slip_cnt);
            end else if (sh_inc == LOCK_V) begin
              state        <= ST_LOCK;
              o_block_lock <= 1'b1;
              sh_cnt       <= '0;
            end else begin
              sh_cnt <= sh_inc;
            end
          end
        end
        // The slip pulse spans exactly one enabled cycle; headers here are ignored.
        ST_SLIP: begin
          o_grbx_slip <= 1'b0;
          wait_cnt    <= '0;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_grbx_hdr_valid) begin
            if (wait_inc == WAIT_V) begin
              state    <= ST_UNLOCK;
              wait_cnt <= '0;
              sh_cnt   <= '0;
              inv_cnt  <= '0;
            end else begin
              wait_cnt <= wait_inc;
            end
          end
        end
        ST_LOCK: begin
          if (i_grbx_hdr_valid) begin
            // Loss of lock wins over the window rollover in the same header.
            if (inv_nxt == INV_MAX_V) begin
              state        <= ST_SLIP;
              o_block_lock <= 1'b0;
              o_grbx_slip  <= 1'b1;
              o_slip_cnt   <= sat_inc8(o_slip_cnt);
              sh_cnt       <= '0;
              inv_cnt      <= '0;
            end else if (sh_inc == LOCK_V) begin
              sh_cnt  <= '0;
              inv_cnt <= '0;
            end else begin
              sh_cnt  <= sh_inc;
              inv_cnt <= inv_nxt;
            end
          end
        end
        default: state <= ST_UNLOCK;
      endcase
    end
  end

  // BER monitor: count invalid headers per window while locked, idle otherwise.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ber_tmr  <= '0;
      ber_cnt  <= '0;
      o_hi_ber <= 1'b0;
    end else if (i_clk_en) begin
      if (!o_block_lock) begin
        ber_tmr  <= '0;
        ber_cnt  <= '0;
        o_hi_ber <= 1'b0;
      end else if (ber_tmr == BER_END_V) begin
        // An invalid header in the closing cycle still belongs to this window.
        ber_tmr  <= '0;
        ber_cnt  <= '0;
        o_hi_ber <= (ber_nxt == BER_TH_V);
      end else begin
        ber_tmr <= ber_tmr + BT_W'(1);
        ber_cnt <= ber_nxt;
        if (ber_nxt == BER_TH_V) o_hi_ber <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eth_pcs_block_sync.sv
// Scoreboard bench for eth_pcs_block_sync: the driver queues hand-computed
// output expectations tagged with the clock edge that produces them, and a
// separate monitor compares them on the following falling edge.
module tb_eth_pcs_block_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       vld;
  logic [1:0] hdr;
  logic       slip;
  logic       lock;
  logic       hib;
  logic       link;
  logic [7:0] scnt;

  always #5 clk = ~clk;

  eth_pcs_block_sync #(.BER_WIN(2048)) dut (
    .i_clk            (clk),
    .i_reset_n        (rst_n),
    .i_clk_en         (en),
    .i_grbx_hdr_valid (vld),
    .i_grbx_hdr       (hdr),
    .o_grbx_slip      (slip),
    .o_block_lock     (lock),
    .o_hi_ber         (hib),
    .o_link_up        (link),
    .o_slip_cnt       (scnt)
  );

  typedef struct {
    int          tag;
    string       name;
    logic [11:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: compare every expectation tagged for the edge just completed.
  exp_t        m;
  logic [11:0] got;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tag <= edge_cnt) begin
      m   = sb.pop_front();
      got = {slip, lock, hib, link, scnt};
      checks++;
      if (m.tag < edge_cnt) begin
        failures++;
        $display("FAIL %s: expectation for edge %0d not compared until edge %0d", m.name, m.tag, edge_cnt);
      end else if (got !== m.v) begin
        failures++;
        $display("FAIL %s: got slip=%b lock=%b hi_ber=%b link=%b slip_cnt=%0d, want slip=%b lock=%b hi_ber=%b link=%b slip_cnt=%0d",
                 m.name, got[11], got[10], got[9], got[8], got[7:0],
                 m.v[11], m.v[10], m.v[9], m.v[8], m.v[7:0]);
      end
    end
  end

  task automatic step(input logic e, input logic v, input logic [1:0] h);
    en  = e;
    vld = v;
    hdr = h;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic s, input logic l, input logic b, input logic [7:0] c);
    exp_t x;
    x.tag  = edge_cnt;
    x.name = n;
    x.v    = {s, l, b, l & ~b, c};
    sb.push_back(x);
  endtask

  task automatic hdrs(input int n, input logic [1:0] h);
    repeat (n) step(1'b1, 1'b1, h);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b1, 1'b0, 2'b01);
    step(1'b1, 1'b0, 2'b01);
    chk("reset", 0, 0, 0, 8'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hi;
    rst_n = 1'b0;
    en    = 1'b0;
    vld   = 1'b0;
    hdr   = 2'b00;

    // Lock after 64 consecutive valid headers.
    do_reset();
    hdrs(63, 2'b01);
    chk("t1_pre_lock", 0, 0, 0, 8'd0);
    hdrs(1, 2'b10);
    chk("t1_lock", 0, 1, 0, 8'd0);

    // Bad header while hunting: slip, settle for 4 headers, relock.
    do_reset();
    hdrs(9, 2'b01);
    hdrs(1, 2'b00);
    chk("t2_slip", 1, 0, 0, 8'd1);
    step(1'b1, 1'b0, 2'b01);
    chk("t2_slip_end", 0, 0, 0, 8'd1);
    hdrs(4, 2'b11);
    chk("t2_wait_ignored", 0, 0, 0, 8'd1);
    hdrs(63, 2'b01);
    chk("t2_pre_relock", 0, 0, 0, 8'd1);
    hdrs(1, 2'b01);
    chk("t2_relock", 0, 1, 0, 8'd1);

    // 15 invalid in a window holds lock; 16 in the next window drops it.
    hdrs(15, 2'b00);
    hdrs(49, 2'b01);
    chk("t3_15inv_hold", 0, 1, 0, 8'd1);
    hdrs(1, 2'b00);
    chk("t3_ber_hi", 0, 1, 1, 8'd1);
    hdrs(14, 2'b00);
    chk("t3_15th_hold", 0, 1, 1, 8'd1);
    hdrs(1, 2'b00);
    chk("t3_lock_lost", 1, 0, 1, 8'd2);
    step(1'b1, 1'b0, 2'b01);
    chk("t3_unlocked", 0, 0, 0, 8'd2);
    hdrs(4, 2'b01);
    hdrs(64, 2'b01);
    chk("t3_relock", 0, 1, 0, 8'd2);

    // 16th invalid on the 64th header of the window: loss wins.
    do_reset();
    hdrs(64, 2'b01);
    chk("t4_lock", 0, 1, 0, 8'd0);
    hdrs(48, 2'b01);
    hdrs(15, 2'b11);
    chk("t4_pre_loss", 0, 1, 0, 8'd0);
    hdrs(1, 2'b11);
    chk("t4_loss_wins", 1, 0, 1, 8'd1);
    step(1'b1, 1'b0, 2'b01);
    chk("t4_after", 0, 0, 0, 8'd1);

    // BER window 2048: one invalid per 64 headers sets hi_ber on the 16th.
    do_reset();
    hdrs(64, 2'b01);
    chk("t5_lock", 0, 1, 0, 8'd0);
    for (int g = 1; g <= 32; g++) begin
      hdrs(63, 2'b01);
      hdrs(1, 2'b00);
      if (g == 15) chk("t5_below_thresh", 0, 1, 0, 8'd0);
      if (g == 16) chk("t5_hi_ber_set", 0, 1, 1, 8'd0);
    end
    chk("t5_win1_end_keep", 0, 1, 1, 8'd0);
    for (int g = 33; g <= 35; g++) begin
      hdrs(63, 2'b01);
      hdrs(1, 2'b00);
    end
    hdrs(64 * 29 - 1, 2'b01);
    chk("t5_pre_win2_end", 0, 1, 1, 8'd0);
    hdrs(1, 2'b01);
    chk("t5_hi_ber_clear", 0, 1, 0, 8'd0);

    // Clock enable 32/33 with invalid headers offered on the low cycles.
    do_reset();
    hi = 0;
    for (int i = 0; hi < 64; i++) begin
      if ((i % 33) == 32) begin
        step(1'b0, 1'b1, 2'b00);
        chk("t6_low_hold", 0, 0, 0, 8'd0);
      end else begin
        step(1'b1, 1'b1, 2'b01);
        hi++;
      end
    end
    chk("t6_lock", 0, 1, 0, 8'd0);

    // Slip pulse stays high across a low-enable gap, then ends.
    do_reset();
    hdrs(1, 2'b00);
    chk("t6_slip", 1, 0, 0, 8'd1);
    step(1'b0, 1'b1, 2'b01);
    chk("t6_slip_held", 1, 0, 0, 8'd1);
    step(1'b1, 1'b0, 2'b01);
    chk("t6_slip_once", 0, 0, 0, 8'd1);

    // Reset asserted during WAIT, then a clean relock.
    hdrs(1, 2'b01);
    rst_n = 1'b0;
    step(1'b1, 1'b1, 2'b00);
    chk("t6_reset_in_wait", 0, 0, 0, 8'd0);
    rst_n = 1'b1;
    hdrs(63, 2'b01);
    chk("t6_pre_relock", 0, 0, 0, 8'd0);
    hdrs(1, 2'b01);
    chk("t6_relock", 0, 1, 0, 8'd0);

    step(1'b1, 1'b0, 2'b01);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left uncompared, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
